mem_nr1w: RTL and testbench
===========================

MEM_NR1W -- requirements
Module: mem_nr1w

Interface
REQ-001 SHALL have parameter NUMRDPT, default 2, number of read ports (1..8).
REQ-002 SHALL have parameter NUMADDR, default 8, number of words.
REQ-003 SHALL have parameter BITADDR, default 3, address width; ceil(log2(NUMADDR)) <= BITADDR.
REQ-004 SHALL have parameter BITDATA, default 1, word width.
REQ-005 SHALL have parameter SRAM_DELAY, default 1, read latency in cycles (1..4).
REQ-006 SHALL have parameter RSTINIT, default 0; 1 enables post-reset array initialisation.
REQ-007 SHALL have parameters RSTSTRT and RSTINCR, default 0, giving the init value of word i as RSTSTRT+i*RSTINCR.
REQ-008 SHALL have parameter BYPASS, default 0; 0 means a same-cycle read of a written address returns old data, 1 means it returns new data.
REQ-009 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-010 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-011 SHALL have port ready, output, 1, high when accesses are accepted.
REQ-012 SHALL have port read, input, NUMRDPT, per-port read request.
REQ-013 SHALL have port rd_adr, input, NUMRDPT*BITADDR, per-port read address; port p uses bits [p*BITADDR +: BITADDR].
REQ-014 SHALL have port rd_vld, output, NUMRDPT, per-port read-data valid.
REQ-015 SHALL have port rd_dout, output, NUMRDPT*BITDATA, per-port read data; port p uses bits [p*BITDATA +: BITDATA].
REQ-016 SHALL have port write, input, 1, write request.
REQ-017 SHALL have ports wr_adr (BITADDR) and wr_din (BITDATA), inputs, giving write address and data.

Function
REQ-018 SHALL have controller states RESET, INIT and RUN.
REQ-019 SHALL move RESET->INIT on the first cycle rst is low if RSTINIT=1, else RESET->RUN.
REQ-020 SHALL write, in INIT, word i with (RSTSTRT+i*RSTINCR) truncated to BITDATA bits, one word per cycle, i = 0..NUMADDR-1, then enter RUN.
REQ-021 SHALL drive ready high only in RUN; after rst falls, ready rises after 1 cycle (RSTINIT=0) or 1+NUMADDR cycles (RSTINIT=1).
REQ-022 SHALL ignore write and read when ready is low: no array update, no rd_vld.
REQ-023 SHALL, in RUN, perform a write with write=1 at the clock edge of that cycle.
REQ-024 SHALL, for read[p]=1 in RUN in cycle t, assert rd_vld[p] and present the word in cycle t+SRAM_DELAY.
REQ-025 SHALL accept a new read on each port every cycle (fully pipelined); ports are independent and may use the same address.
REQ-026 SHALL, when a read and write target the same address in the same cycle, return wr_din if BYPASS=1, else the pre-write value.
REQ-027 SHALL drive rd_dout[p] to 0 whenever rd_vld[p] is low.
REQ-028 SHALL treat addresses >= NUMADDR as no-ops for writes and return 0 with rd_vld high for reads.
REQ-029 SHALL return contents of a never-written word (RSTINIT=0) as 0 in simulation and synthesis alike.

Reset
REQ-030 SHALL, while rst is high, hold ready=0, rd_vld=0, rd_dout=0, state RESET, init counter 0, and flush the read pipeline.
REQ-031 SHALL, on rst during INIT or RUN, abort and restart per REQ-019 without completing in-flight reads.
REQ-032 SHALL clear array contents on reset only through the INIT sequence (RSTINIT=1) or an explicit zero-fill when RSTINIT=0.

Structure
REQ-033 SHALL take the state enumeration and the init-value function from shared package mem_pkg.
REQ-034 SHALL implement the read latency pipeline with the existing sub-module shift (BITDATA*NUMRDPT+NUMRDPT wide, DELAY=SRAM_DELAY-1).
REQ-035 SHALL implement the array as a single register file with one write port and NUMRDPT read ports.

Verification
REQ-036 SHALL test init: RSTINIT=1, NUMADDR=8, BITDATA=4, RSTSTRT=3, RSTINCR=5 -> ready after 9 cycles; reading addresses 0..7 returns 3,8,13,2,7,12,1,6.
REQ-037 SHALL test latency: SRAM_DELAY=3, write 0xA to address 5, then read port 1 address 5 -> rd_vld[1]=1 and rd_dout=0xA exactly 3 cycles later.
REQ-038 SHALL test collision: address 2 holds 0x1, same-cycle write 0x9 and read of address 2 -> returns 0x1 with BYPASS=0, 0x9 with BYPASS=1.
REQ-039 SHALL test the not-ready gate: write 0xF to address 0 during INIT -> ignored, address 0 reads the init value.
REQ-040 SHALL test reset mid-operation: rst for 1 cycle at INIT step 4 -> init restarts at word 0, ready only after the full sequence, no stray rd_vld.
REQ-041 SHALL test concurrency: NUMRDPT=4, all ports read distinct addresses every cycle for 20 cycles -> every rd_vld/rd_dout matches the scoreboard.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared controller states and init-value helper for the mem_nr1w register-file memory.
package mem_pkg;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    INIT  = 2'd1,
    RUN   = 2'd2
  } mem_state_t;

  // Callers truncate the result to their own word width.
  function automatic logic [63:0] init_value(input logic [63:0] strt,
                                             input logic [63:0] incr,
                                             input logic [63:0] idx);
    return strt + idx * incr;
  endfunction

endpackage

// File: rtl/shift.sv
// Resettable delay line of DELAY register stages; DELAY=0 is a plain wire.
// No flow control: data advances every cycle.
module shift #(
  parameter int WIDTH = 1,
  parameter int DELAY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DELAY == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DELAY];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DELAY; i++) stage[i] <= '0;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DELAY; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DELAY-1];
    end
  endgenerate

endmodule

// File: rtl/mem_nr1w.sv
// NUMRDPT-read / 1-write register-file memory with optional post-reset init; read latency SRAM_DELAY.
// No backpressure: accepts one access per port per cycle whenever ready is high.
module mem_nr1w
  import mem_pkg::*;
#(
  parameter int NUMRDPT    = 2,
  parameter int NUMADDR    = 8,
  parameter int BITADDR    = 3,
  parameter int BITDATA    = 1,
  parameter int SRAM_DELAY = 1,
  parameter int RSTINIT    = 0,
  parameter int RSTSTRT    = 0,
  parameter int RSTINCR    = 0,
  parameter int BYPASS     = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       ready,
  input  logic [NUMRDPT-1:0]         read,
  input  logic [NUMRDPT*BITADDR-1:0] rd_adr,
  output logic [NUMRDPT-1:0]         rd_vld,
  output logic [NUMRDPT*BITDATA-1:0] rd_dout,
  input  logic                       write,
  input  logic [BITADDR-1:0]         wr_adr,
  input  logic [BITDATA-1:0]         wr_din
);

  localparam int AW = (NUMADDR > 1) ? $clog2(NUMADDR) : 1;
  localparam int PW = NUMRDPT * BITDATA + NUMRDPT;

  mem_state_t         state, state_nxt;
  logic [BITADDR-1:0] init_cnt;
  logic               init_last;
  logic               init_en;
  logic [BITDATA-1:0] mem [NUMADDR];
  logic               wr_hit;

  assign init_last = (init_cnt == BITADDR'(NUMADDR - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= RESET;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RESET:   state_nxt = (RSTINIT != 0) ? INIT : RUN;
      INIT:    state_nxt = init_last ? RUN : INIT;
      RUN:     state_nxt = RUN;
      default: state_nxt = RESET;
    endcase
  end

  // rst masks ready so nothing is accepted in the cycle reset is asserted.
  always_comb begin
    ready   = (state == RUN) && !rst;
    init_en = (state == INIT) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst)                       init_cnt <= '0;
    else if (init_en && init_last) init_cnt <= '0;
    else if (init_en)              init_cnt <= init_cnt + 1'b1;
  end

  assign wr_hit = ready && write && (32'(wr_adr) < NUMADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      if (RSTINIT == 0) begin
        for (int i = 0; i < NUMADDR; i++) mem[i] <= '0;
      end
    end else if (init_en) begin
      mem[init_cnt[AW-1:0]] <= BITDATA'(init_value(64'(RSTSTRT), 64'(RSTINCR), 64'(init_cnt)));
    end else if (wr_hit) begin
      mem[wr_adr[AW-1:0]] <= wr_din;
    end
  end

  logic [NUMRDPT-1:0]         rd_acc;
  logic [NUMRDPT*BITDATA-1:0] rd_word;

  always_comb begin
    rd_acc  = '0;
    rd_word = '0;
    for (int p = 0; p < NUMRDPT; p++) begin
      if (ready && read[p]) begin
        rd_acc[p] = 1'b1;
        if (32'(rd_adr[p*BITADDR +: BITADDR]) < NUMADDR) begin
          if (BYPASS != 0 && wr_hit && wr_adr == rd_adr[p*BITADDR +: BITADDR])
            rd_word[p*BITDATA +: BITDATA] = wr_din;
          else
            rd_word[p*BITDATA +: BITDATA] = mem[rd_adr[p*BITADDR +: AW]];
        end
      end
    end
  end

  logic [PW-1:0] rd_stg;
  logic [PW-1:0] pipe_out;

  always_ff @(posedge clk) begin
    if (rst) rd_stg <= '0;
    else     rd_stg <= {rd_acc, rd_word};
  end

  shift #(
    .WIDTH (PW),
    .DELAY (SRAM_DELAY - 1)
  ) u_shift (
    .clk  (clk),
    .rst  (rst),
    .din  (rd_stg),
    .dout (pipe_out)
  );

  assign rd_vld  = pipe_out[PW-1 -: NUMRDPT] & {NUMRDPT{~rst}};
  assign rd_dout = rst ? '0 : pipe_out[NUMRDPT*BITDATA-1:0];

endmodule

// File: tb/tb_mem_nr1w.sv
// Two mem_nr1w instances (init/no-bypass/delay 3 and zero-fill/bypass/delay 1) on shared
// stimulus, checked every cycle against a per-instance array-and-schedule reference model.
module tb_mem_nr1w;

  localparam int NP = 4;
  localparam int NA = 8;
  localparam int BA = 4;
  localparam int BD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [NP-1:0]    read;
  logic [NP*BA-1:0] rd_adr;
  logic             write;
  logic [BA-1:0]    wr_adr;
  logic [BD-1:0]    wr_din;
  logic             ready_a, ready_b;
  logic [NP-1:0]    vld_a, vld_b;
  logic [NP*BD-1:0] dout_a, dout_b;

  mem_nr1w #(.NUMRDPT(NP), .NUMADDR(NA), .BITADDR(BA), .BITDATA(BD), .SRAM_DELAY(3),
             .RSTINIT(1), .RSTSTRT(3), .RSTINCR(5), .BYPASS(0)) u_dut_a (
    .clk(clk), .rst(rst), .ready(ready_a), .read(read), .rd_adr(rd_adr),
    .rd_vld(vld_a), .rd_dout(dout_a), .write(write), .wr_adr(wr_adr), .wr_din(wr_din));

  mem_nr1w #(.NUMRDPT(NP), .NUMADDR(NA), .BITADDR(BA), .BITDATA(BD), .SRAM_DELAY(1),
             .RSTINIT(0), .RSTSTRT(3), .RSTINCR(5), .BYPASS(1)) u_dut_b (
    .clk(clk), .rst(rst), .ready(ready_b), .read(read), .rd_adr(rd_adr),
    .rd_vld(vld_b), .rd_dout(dout_b), .write(write), .wr_adr(wr_adr), .wr_din(wr_din));

  // Reference configuration: cycles-to-ready after rst falls, read latency, bypass, init.
  int          lat_cfg [2] = '{9, 1};
  int          dly_cfg [2] = '{3, 1};
  bit          byp_cfg [2] = '{1'b0, 1'b1};
  bit          ini_cfg [2] = '{1'b1, 1'b0};
  int          init_tab [NA] = '{3, 8, 13, 2, 7, 12, 1, 6};

  int          mdl_mem [2][NA];
  int          since_rst [2];
  logic [31:0] exp_vld [2][8];
  logic [31:0] exp_dat [2][8];
  int          cyc;
  int          vec_cnt;
  int          err_cnt;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s cyc=%0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic idle();
    read   = '0;
    rd_adr = '0;
    write  = 1'b0;
    wr_adr = '0;
    wr_din = '0;
  endtask

  task automatic set_rd(input int p, input int a);
    read[p]           = 1'b1;
    rd_adr[p*BA +: BA] = BA'(a);
  endtask

  task automatic set_wr(input int a, input int v);
    write  = 1'b1;
    wr_adr = BA'(a);
    wr_din = BD'(v);
  endtask

  // One clock cycle: check outputs for this cycle, then apply this cycle's inputs to the model.
  task automatic tick();
    int          slot;
    logic        rdy;
    logic [31:0] o_rdy, o_vld, o_dat, e_vld, e_dat;
    slot = cyc % 8;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      rdy = !rst && (since_rst[d] >= lat_cfg[d]);
      if (d == 0) begin
        o_rdy = 32'(ready_a); o_vld = 32'(vld_a); o_dat = 32'(dout_a);
      end else begin
        o_rdy = 32'(ready_b); o_vld = 32'(vld_b); o_dat = 32'(dout_b);
      end
      e_vld = rst ? 32'd0 : exp_vld[d][slot];
      e_dat = rst ? 32'd0 : exp_dat[d][slot];
      check_val($sformatf("ready%0d", d), o_rdy, 32'(rdy));
      check_val($sformatf("rd_vld%0d", d), o_vld, e_vld);
      check_val($sformatf("rd_dout%0d", d), o_dat, e_dat);
      exp_vld[d][slot] = '0;
      exp_dat[d][slot] = '0;
      if (rst) begin
        for (int s = 0; s < 8; s++) begin
          exp_vld[d][s] = '0;
          exp_dat[d][s] = '0;
        end
        for (int i = 0; i < NA; i++) mdl_mem[d][i] = ini_cfg[d] ? init_tab[i] : 0;
        since_rst[d] = 0;
      end else begin
        for (int p = 0; p < NP; p++) begin
          if (rdy && read[p]) begin
            int a, v, s;
            a = int'(rd_adr[p*BA +: BA]);
            if (a >= NA)                                   v = 0;
            else if (byp_cfg[d] && write && int'(wr_adr) == a) v = int'(wr_din);
            else                                           v = mdl_mem[d][a];
            s = (cyc + dly_cfg[d]) % 8;
            exp_vld[d][s] = exp_vld[d][s] | (32'd1 << p);
            exp_dat[d][s] = exp_dat[d][s] | (32'(v) << (p * BD));
          end
        end
        if (rdy && write && int'(wr_adr) < NA) mdl_mem[d][int'(wr_adr)] = int'(wr_din);
        since_rst[d]++;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    cyc     = 0;
    for (int d = 0; d < 2; d++) begin
      since_rst[d] = 0;
      for (int s = 0; s < 8; s++) begin
        exp_vld[d][s] = '0;
        exp_dat[d][s] = '0;
      end
      for (int i = 0; i < NA; i++) mdl_mem[d][i] = 0;
    end
    idle();
    rst = 1'b1;
    repeat (3) tick();

    // Init sequence with an ignored write and a reset pulse at init step 4.
    rst = 1'b0;
    tick(); tick();
    set_wr(0, 15); tick(); idle();
    tick();
    rst = 1'b1; tick(); rst = 1'b0;
    tick(); tick(); tick();
    set_wr(0, 15); tick(); idle();
    repeat (8) tick();

    // Read back every word across all four ports.
    for (int p = 0; p < NP; p++) set_rd(p, p);
    tick(); idle();
    for (int p = 0; p < NP; p++) set_rd(p, p + 4);
    tick(); idle();
    repeat (4) tick();

    // Latency: write then read port 1.
    set_wr(5, 10); tick(); idle();
    set_rd(1, 5); tick(); idle();
    repeat (4) tick();

    // Same-cycle read/write collision.
    set_wr(2, 1); tick(); idle();
    set_wr(2, 9); set_rd(0, 2); tick(); idle();
    repeat (4) tick();

    // All ports read distinct addresses every cycle.
    for (int c = 0; c < 20; c++) begin
      int base;
      base = $urandom_range(0, NA - 1);
      idle();
      for (int p = 0; p < NP; p++) set_rd(p, (base + 2 * p) % NA);
      if ($urandom_range(0, 1) == 1) set_wr($urandom_range(0, NA - 1), $urandom_range(0, 15));
      tick();
    end
    idle();
    repeat (4) tick();

    // Random traffic including out-of-range addresses and occasional resets.
    for (int c = 0; c < 400; c++) begin
      idle();
      for (int p = 0; p < NP; p++)
        if ($urandom_range(0, 2) != 0) set_rd(p, $urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) set_wr($urandom_range(0, 15), $urandom_range(0, 15));
      rst = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 1'b0;
    idle();
    repeat (12) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
